// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet datapath: FP32 field positions,
// special encodings and the accumulator state encoding.
package maxnet_pkg;

   localparam int FP_W    = 32;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;

   localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
   localparam logic [7:0]      FP_EXP_INF = 8'hFF;
   localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } acc_state_t;

endpackage

// File: rtl/fp_accumulator_if.sv
// Term stream in, packet-sum stream out. The master side is whoever feeds
// terms and consumes sums; the slave side is the accumulator.
interface fp_accumulator_if #(
   parameter int CNT_W = 5
);
   import maxnet_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [FP_W-1:0]  in_data;
   logic             in_last;
   logic             sum_valid;
   logic             sum_ready;
   logic [FP_W-1:0]  sum_data;
   logic [CNT_W-1:0] sum_count;
   logic             sum_overflow;
   logic             sum_len_err;

   modport master (
      output in_valid, in_data, in_last, sum_ready,
      input  in_ready, sum_valid, sum_data, sum_count, sum_overflow, sum_len_err
   );

   modport slave (
      input  in_valid, in_data, in_last, sum_ready,
      output in_ready, sum_valid, sum_data, sum_count, sum_overflow, sum_len_err
   );

endinterface

// File: rtl/fp_accumulator_adder.sv
// Combinational FP32 adder, round-to-nearest-even. Subnormal inputs are
// flushed to zero and underflowing results become +0. Overflow returns a
// signed infinity and raises the overflow flag; Inf/NaN operands propagate.
module Adder
   import maxnet_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] out,
   output logic            overflow
);

   logic [FP_W-1:0]   w_big;
   logic [FP_W-1:0]   w_sml;
   logic [7:0]        w_eb;
   logic [7:0]        w_es;
   logic [7:0]        w_diff;
   logic [23:0]       w_mb;
   logic [23:0]       w_ms;
   logic [49:0]       w_shift;
   logic              w_sticky;
   logic [26:0]       w_al_b;
   logic [26:0]       w_al_s;
   logic [27:0]       w_sum;
   logic [26:0]       w_norm;
   logic signed [9:0] w_exp;
   logic [4:0]        w_lz;
   logic [24:0]       w_rnd;
   logic [22:0]       w_frac;

   // Order operands by magnitude so the subtraction below never goes negative.
   assign w_big = (a[FP_W-2:0] >= b[FP_W-2:0]) ? a : b;
   assign w_sml = (a[FP_W-2:0] >= b[FP_W-2:0]) ? b : a;
   assign w_eb  = w_big[EXP_MSB:EXP_LSB];
   assign w_es  = w_sml[EXP_MSB:EXP_LSB];
   assign w_mb  = (w_eb != 8'h00) ? {1'b1, w_big[EXP_LSB-1:0]} : 24'h0;
   assign w_ms  = (w_es != 8'h00) ? {1'b1, w_sml[EXP_LSB-1:0]} : 24'h0;

   // Align the smaller operand, keeping guard, round and sticky bits.
   assign w_diff   = w_eb - w_es;
   assign w_shift  = {w_ms, 26'h0} >> w_diff;
   assign w_sticky = (|w_shift[23:0]) | ((w_diff > 8'd49) & (|w_ms));
   assign w_al_b   = {w_mb, 3'b000};
   assign w_al_s   = {w_shift[49:24], w_sticky};
   assign w_sum    = (w_big[FP_W-1] ^ w_sml[FP_W-1]) ? ({1'b0, w_al_b} - {1'b0, w_al_s})
                                                     : ({1'b0, w_al_b} + {1'b0, w_al_s});

   // Normalise, round to nearest-even, then classify the result.
   always_comb begin
      w_lz     = 5'd0;
      w_norm   = 27'h0;
      w_exp    = $signed({2'b00, w_eb});
      w_rnd    = 25'h0;
      w_frac   = 23'h0;
      out      = FP_ZERO;
      overflow = 1'b0;
      if (w_sum[27]) begin
         w_norm = {w_sum[27:2], |w_sum[1:0]};
         w_exp  = w_exp + 10'sd1;
      end else begin
         for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
         end
         w_norm = w_sum[26:0] << w_lz;
         w_exp  = w_exp - $signed({5'b00000, w_lz});
      end
      w_rnd = {1'b0, w_norm[26:3]} + 25'(w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]));
      if (w_rnd[24]) begin
         w_frac = w_rnd[23:1];
         w_exp  = w_exp + 10'sd1;
      end else begin
         w_frac = w_rnd[22:0];
      end
      if (w_eb == FP_EXP_INF) begin
         // Inf - Inf is invalid; anything else returns the special operand.
         if ((w_es == FP_EXP_INF) && (w_big[FP_W-1] != w_sml[FP_W-1]) &&
             (w_big[22:0] == 23'h0) && (w_sml[22:0] == 23'h0))
            out = FP_QNAN;
         else
            out = w_big;
      end else if ((w_sum == 28'h0) || (w_exp <= 10'sd0)) begin
         out = FP_ZERO;
      end else if (w_exp >= 10'sd255) begin
         out      = {w_big[FP_W-1], FP_EXP_INF, 23'h0};
         overflow = 1'b1;
      end else begin
         out = {w_big[FP_W-1], w_exp[7:0], w_frac};
      end
   end

endmodule

// File: rtl/fp_accumulator.sv
// Packet accumulator: sums a stream of FP32 terms into a loop register and
// offers the packet sum downstream with count, overflow and length flags.
module fp_accumulator
   import maxnet_pkg::*;
#(
   parameter int MAX_TERMS = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_accumulator_if.slave bus
);

   localparam int               CNT_W  = $clog2(MAX_TERMS + 1);
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_TERMS);

   acc_state_t       r_state;
   acc_state_t       w_state_nxt;
   logic [FP_W-1:0]  r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_len_err;
   logic [FP_W-1:0]  w_add_out;
   logic             w_add_ovf;
   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_full;

   Adder u_add (
      .a        (r_acc),
      .b        (bus.in_data),
      .out      (w_add_out),
      .overflow (w_add_ovf)
   );

   // in_ready depends only on registered state, so DONE always costs a bubble.
   assign w_accept  = bus.in_valid & (r_state != DONE);
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_full    = (w_cnt_inc == LP_MAX);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: a packet closes on in_last or when the term limit is reached.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && (bus.in_last || (MAX_TERMS == 1))) w_state_nxt = DONE;
            else if (w_accept)                                 w_state_nxt = ACC;
         end
         ACC: begin
            if (w_accept && (bus.in_last || w_full)) w_state_nxt = DONE;
         end
         DONE: begin
            if (bus.sum_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Running sum, term count and sticky flags; the first beat bypasses the adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= FP_ZERO;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_len_err <= 1'b0;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            r_acc     <= bus.in_data;
            r_cnt     <= CNT_W'(1);
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
         end else begin
            r_acc     <= w_add_out;
            r_cnt     <= w_cnt_inc;
            r_ovf     <= r_ovf | w_add_ovf | (w_add_out[EXP_MSB:EXP_LSB] == FP_EXP_INF);
            r_len_err <= ~bus.in_last & w_full;
         end
      end
   end

   assign bus.in_ready     = (r_state != DONE);
   assign bus.sum_valid    = (r_state == DONE);
   assign bus.sum_data     = r_acc;
   assign bus.sum_count    = r_cnt;
   assign bus.sum_overflow = r_ovf;
   assign bus.sum_len_err  = r_len_err;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator with a 4-term packet limit: directed cases for
// each documented behaviour, then random integer-valued packets whose sums
// are exact in FP32 and are predicted from plain integer arithmetic.
module tb_fp_accumulator;

   localparam int MAXT = 4;
   localparam int CW   = $clog2(MAXT + 1);

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   fp_accumulator_if #(.CNT_W(CW)) bus ();

   fp_accumulator #(.MAX_TERMS(MAXT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] int2fp(input int n);
      int   m;
      int   p;
      logic s;
      if (n == 0) return 32'h0;
      s = (n < 0);
      m = s ? -n : n;
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat, wait (bounded) for in_ready, let it be accepted.
   task automatic send(input logic [31:0] d, input logic last);
      int k;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      k = 0;
      while (!bus.in_ready && k < 50) begin
         tick();
         k++;
      end
      chk("in_ready_wait", {31'h0, bus.in_ready}, 32'h1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Check a presented sum, then complete the handshake.
   task automatic check_sum(input string tag, input logic [31:0] d, input int cnt,
                            input logic ovf, input logic len);
      chk({tag, "_valid"}, {31'h0, bus.sum_valid}, 32'h1);
      chk({tag, "_inrdy"}, {31'h0, bus.in_ready}, 32'h0);
      chk({tag, "_data"}, bus.sum_data, d);
      chk({tag, "_count"}, 32'(bus.sum_count), 32'(cnt));
      chk({tag, "_ovf"}, {31'h0, bus.sum_overflow}, {31'h0, ovf});
      chk({tag, "_len"}, {31'h0, bus.sum_len_err}, {31'h0, len});
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk({tag, "_vld_drop"}, {31'h0, bus.sum_valid}, 32'h0);
   endtask

   initial begin
      int pkt_sum;
      int pkt_n;
      int v;
      logic last;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_last   = 1'b0;
      bus.sum_ready = 1'b0;
      #12;
      chk("rst_valid", {31'h0, bus.sum_valid}, 32'h0);
      chk("rst_inrdy", {31'h0, bus.in_ready}, 32'h1);
      chk("rst_data", bus.sum_data, 32'h0);
      chk("rst_count", 32'(bus.sum_count), 32'h0);
      chk("rst_flags", {30'h0, bus.sum_overflow, bus.sum_len_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single-term packet.
      send(32'h40A0_0000, 1'b1);
      check_sum("single", 32'h40A0_0000, 1, 1'b0, 1'b0);

      // 2.0 + 4.0
      send(32'h4000_0000, 1'b0);
      send(32'h4080_0000, 1'b1);
      check_sum("two", 32'h40C0_0000, 2, 1'b0, 1'b0);

      // Exact cancellation.
      send(32'h4040_0000, 1'b0);
      send(32'hC040_0000, 1'b1);
      check_sum("cancel", 32'h0000_0000, 2, 1'b0, 1'b0);

      // Overflow to infinity, then cleared by the next packet.
      send(32'h7F00_0000, 1'b0);
      send(32'h7F00_0000, 1'b1);
      check_sum("ovf", 32'h7F80_0000, 2, 1'b1, 1'b0);
      send(32'h3F80_0000, 1'b1);
      check_sum("ovf_clr", 32'h3F80_0000, 1, 1'b0, 1'b0);

      // Packet closed by the term limit; the next beat waits through DONE.
      for (int i = 0; i < MAXT; i++) send(32'h4000_0000, 1'b0);
      chk("lim_valid", {31'h0, bus.sum_valid}, 32'h1);
      chk("lim_count", 32'(bus.sum_count), 32'(MAXT));
      chk("lim_len", {31'h0, bus.sum_len_err}, 32'h1);
      chk("lim_data", bus.sum_data, 32'h4100_0000);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4040_0000;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("lim_hold_inrdy", {31'h0, bus.in_ready}, 32'h0);
         chk("lim_hold_count", 32'(bus.sum_count), 32'(MAXT));
      end
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk("lim_turn_valid", {31'h0, bus.sum_valid}, 32'h0);
      chk("lim_turn_inrdy", {31'h0, bus.in_ready}, 32'h1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check_sum("lim_next", 32'h4040_0000, 1, 1'b0, 1'b0);

      // Downstream backpressure holds the sum stable.
      send(32'h4000_0000, 1'b0);
      send(32'h4080_0000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", bus.sum_data, 32'h40C0_0000);
         chk("bp_inrdy", {31'h0, bus.in_ready}, 32'h0);
         tick();
      end
      check_sum("bp", 32'h40C0_0000, 2, 1'b0, 1'b0);

      // Reset mid-packet discards the partial sum.
      send(32'h40E0_0000, 1'b0);
      send(32'h40E0_0000, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mrst_valid", {31'h0, bus.sum_valid}, 32'h0);
      chk("mrst_inrdy", {31'h0, bus.in_ready}, 32'h1);
      chk("mrst_data", bus.sum_data, 32'h0);
      chk("mrst_count", 32'(bus.sum_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mrst_no_emit", {31'h0, bus.sum_valid}, 32'h0);
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b1);
      check_sum("mrst_fresh", 32'h4040_0000, 2, 1'b0, 1'b0);

      // Random integer-valued packets against an integer reference sum.
      pkt_sum = 0;
      pkt_n   = 0;
      for (int i = 0; i < 60; i++) begin
         v    = int'($urandom_range(0, 2000)) - 1000;
         last = ($urandom_range(0, 3) == 0);
         send(int2fp(v), last);
         pkt_sum += v;
         pkt_n++;
         if (last || pkt_n == MAXT) begin
            check_sum("rnd", int2fp(pkt_sum), pkt_n, 1'b0, !last);
            pkt_sum = 0;
            pkt_n   = 0;
         end
      end
      if (pkt_n != 0) begin
         send(int2fp(0), 1'b1);
         pkt_n++;
         check_sum("rnd_tail", int2fp(pkt_sum), pkt_n, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
